spart_bus_ctrl: RTL and testbench
=================================

// Module: spart_bus_ctrl
// PURPOSE
//   Processor-side controller for the SPART: decodes iocs/iorw/ioaddr, arbitrates the shared
//   8-bit databus between the receive buffer, status and divisor readback, and routes write
//   strobes to the transmit side. Holds the 16-bit divisor buffer (DB) and runs the baud
//   generator that produces the 'enable' tick consumed by the receive and transmit buffers.
// PARAMETERS
//   RESET_DIV  16'h0000  divisor loaded at reset; 0 = unconfigured (no ticks until DB written)
// PORTS
//   clk       in    1   system clock
//   rst       in    1   synchronous, active-high reset
//   iocs      in    1   chip select
//   iorw      in    1   1 = read, 0 = write
//   ioaddr    in    2   register select
//   databus   inout 8   shared processor bus
//   rda       in    1   receive data available (from receive buffer)
//   tbr       in    1   transmit buffer ready (from transmit buffer)
//   rx_data   in    8   received character
//   rx_rd     out   1   1-cycle pulse: receive buffer read (clears rda)
//   tx_wr     out   1   1-cycle pulse: transmit buffer load
//   tx_data   out   8   character to transmit, valid while tx_wr=1
//   enable    out   1   baud tick, 1 cycle wide, period = divisor clocks
// BEHAVIOUR
// - Address map: 00 R rx_data / W tx_data; 01 R {6'b0,tbr,rda} / W ignored;
//   10 R/W DB low byte; 11 R/W DB high byte.
// - databus driven only when iocs & iorw (combinational, same cycle); otherwise 8'hzz.
//   Never driven when iocs=0 or iorw=0.
// - Access edge detect: register acc_q = iocs. First cycle of an access = iocs & ~acc_q, or
//   iocs & (ioaddr/iorw changed from the previous cycle). A held access produces ONE strobe.
// - rx_rd: registered; 1 the cycle after the first cycle of a read at 00. Asserted even if rda=0.
// - tx_wr/tx_data: registered; tx_data captures databus on the first cycle of a write at 00,
//   and tx_wr = 1 the following cycle. tbr is not checked (software's job); tx_data holds until next write.
// - Divisor FSM (state regs + db_lo, db_hi):
//   IDLE  : enable=0, counter held. W 10 -> db_lo <= bus, go WAIT_HI. W 11 -> db_hi <= bus, stay.
//   WAIT_HI: enable=0. W 11 -> db_hi <= bus, load counter, go RUN. W 10 -> overwrite db_lo, stay.
//   RUN   : counter decrements each clk; at 0: enable=1 that cycle, reload {db_hi,db_lo}-1.
//           W 10 -> db_lo <= bus, go WAIT_HI (ticks stop immediately). W 11 -> db_hi <= bus,
//           reload counter, stay RUN (phase restarts).
// - Counter load value = max(div,1)-1; divisor 0 or 1 -> enable high every cycle in RUN.
// - First tick after entering RUN occurs exactly div cycles after the db_hi write cycle.
// - Reset: state = (RESET_DIV==0) ? IDLE : RUN; {db_hi,db_lo}=RESET_DIV; counter=max(RESET_DIV,1)-1;
//   enable=0, rx_rd=0, tx_wr=0, tx_data=8'h00, acc_q=0. Reset mid-access or mid-count aborts
//   everything; a pending strobe is dropped.
// - Status read reflects rda/tbr sampled combinationally in the same cycle.
// - Simultaneous: a DB write and a counter-zero in the same cycle: the tick still fires,
//   and the write's transition/reload wins over the normal reload.
// STRUCTURE
// - Shared package spart_pkg: ADDR_DATA=2'b00, ADDR_STATUS=2'b01, ADDR_DB_LO=2'b10,
//   ADDR_DB_HI=2'b11; divisor FSM state enum {IDLE, WAIT_HI, RUN}.
// - One sub-module: spart_baud_gen (16-bit down-counter, load/run/tick); FSM, decode and bus
//   mux stay in spart_bus_ctrl.
// TESTING
// 1. Reset, RESET_DIV=0 -> enable stays 0 for 1000 cycles; status read returns 8'h00 with rda=tbr=0.
// 2. W 10=8'h05, W 11=8'h00 -> first enable 5 clks after hi write, then every 5 clks; R 10 = 8'h05.
// 3. In RUN, W 10=8'h03 -> enable stops; W 11=8'h00 -> period becomes 3.
// 4. Read at 00 held 4 cycles with rx_data=8'hA5 -> databus=8'hA5 all 4 cycles, exactly one rx_rd pulse.
// 5. Write at 00 with databus=8'h3C held 3 cycles -> one tx_wr pulse, tx_data=8'h3C; iorw=0 -> databus z.
// 6. Divisor 0 written -> enable=1 every cycle; assert rst mid-RUN -> next cycle enable=0, state IDLE.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART processor-side controller: register map,
// divisor FSM states and the divisor-to-counter load conversion.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        RUN     = 2'd2
    } div_state_t;

    // Divisors 0 and 1 both collapse to a load of 0, giving a tick every cycle.
    function automatic logic [15:0] div_load(input logic [15:0] div);
        return (div == 16'd0) ? 16'd0 : div - 16'd1;
    endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// 16-bit down-counter baud generator: ticks while running whenever the count is
// zero, then reloads; an explicit load restarts the phase.
module spart_baud_gen #(
    parameter logic [15:0] RESET_CNT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_run,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    input  logic [15:0] i_reload_val,
    output logic        o_tick
);

    logic [15:0] r_cnt;
    logic        w_zero;

    assign w_zero = (r_cnt == 16'd0);
    assign o_tick = i_run & w_zero;

    // An explicit load outranks the terminal-count reload in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= RESET_CNT;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_run) begin
            r_cnt <= w_zero ? i_reload_val : r_cnt - 16'd1;
        end
    end

endmodule

// File: rtl/spart_bus_ctrl.sv
// SPART processor-side controller: access decode with one strobe per access,
// databus read mux, transmit write path, divisor buffer FSM and baud generator.
module spart_bus_ctrl
    import spart_pkg::*;
#(
    parameter logic [15:0] RESET_DIV = 16'h0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    input  logic       rda,
    input  logic       tbr,
    input  logic [7:0] rx_data,
    output logic       rx_rd,
    output logic       tx_wr,
    output logic [7:0] tx_data,
    output logic       enable
);

    logic       r_acc_q;
    logic       r_rw_q;
    logic [1:0] r_addr_q;
    logic       r_rx_rd;
    logic       r_tx_wr;
    logic [7:0] r_tx_data;
    logic [7:0] r_db_lo;
    logic [7:0] r_db_hi;
    div_state_t r_state;

    logic        w_first;
    logic        w_wr_data;
    logic        w_rd_data;
    logic        w_wr_lo;
    logic        w_wr_hi;
    logic        w_load;
    logic [15:0] w_load_val;
    logic [15:0] w_reload_val;
    logic [7:0]  w_bus_out;
    logic        w_tick;

    // A new access starts on chip-select rising or on any change of target/direction.
    assign w_first   = iocs & (~r_acc_q | (ioaddr != r_addr_q) | (iorw != r_rw_q));
    assign w_rd_data = w_first &  iorw & (ioaddr == ADDR_DATA);
    assign w_wr_data = w_first & ~iorw & (ioaddr == ADDR_DATA);
    assign w_wr_lo   = w_first & ~iorw & (ioaddr == ADDR_DB_LO);
    assign w_wr_hi   = w_first & ~iorw & (ioaddr == ADDR_DB_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_q   <= 1'b0;
            r_rw_q    <= 1'b0;
            r_addr_q  <= 2'b00;
            r_rx_rd   <= 1'b0;
            r_tx_wr   <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_acc_q  <= iocs;
            r_rw_q   <= iorw;
            r_addr_q <= ioaddr;
            r_rx_rd  <= w_rd_data;
            r_tx_wr  <= w_wr_data;
            if (w_wr_data) begin
                r_tx_data <= databus;
            end
        end
    end

    always_comb begin
        w_bus_out = rx_data;
        case (ioaddr)
            ADDR_DATA:   w_bus_out = rx_data;
            ADDR_STATUS: w_bus_out = {6'b000000, tbr, rda};
            ADDR_DB_LO:  w_bus_out = r_db_lo;
            ADDR_DB_HI:  w_bus_out = r_db_hi;
            default:     w_bus_out = rx_data;
        endcase
    end

    assign databus = (iocs & iorw) ? w_bus_out : 8'hzz;

    // The high-byte write completes a divisor update; the low byte alone parks the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= (RESET_DIV == 16'h0000) ? IDLE : RUN;
            r_db_lo <= RESET_DIV[7:0];
            r_db_hi <= RESET_DIV[15:8];
        end else begin
            if (w_wr_lo) begin
                r_db_lo <= databus;
            end
            if (w_wr_hi) begin
                r_db_hi <= databus;
            end
            case (r_state)
                IDLE:    if (w_wr_lo) r_state <= WAIT_HI;
                WAIT_HI: if (w_wr_hi) r_state <= RUN;
                RUN:     if (w_wr_lo) r_state <= WAIT_HI;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_load       = w_wr_hi & (r_state != IDLE);
    assign w_load_val   = div_load({databus, r_db_lo});
    assign w_reload_val = div_load({r_db_hi, r_db_lo});

    spart_baud_gen #(
        .RESET_CNT (div_load(RESET_DIV))
    ) u_baud_gen (
        .clk          (clk),
        .rst          (rst),
        .i_run        (r_state == RUN),
        .i_load       (w_load),
        .i_load_val   (w_load_val),
        .i_reload_val (w_reload_val),
        .o_tick       (w_tick)
    );

    assign rx_rd   = r_rx_rd;
    assign tx_wr   = r_tx_wr;
    assign tx_data = r_tx_data;
    assign enable  = w_tick;

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Bench for spart_bus_ctrl: directed scenarios plus randomized bus traffic checked
// against a cycle-indexed model of ticks, strobes and register contents.
module tb_spart_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    wire  [7:0] databus;
    logic       rda = 1'b0;
    logic       tbr = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rd;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       enable;

    logic       tb_drv = 1'b0;
    logic [7:0] tb_wd = 8'h00;

    assign databus = tb_drv ? tb_wd : 8'hzz;

    spart_bus_ctrl #(.RESET_DIV(16'h0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .rx_data (rx_data),
        .rx_rd   (rx_rd),
        .tx_wr   (tx_wr),
        .tx_data (tx_data),
        .enable  (enable)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic rnd_in = 1'b1;

    // Model: mode 0 = unconfigured, 1 = waiting for high byte, 2 = ticking.
    // While ticking, ticks fall at m_t0 + k*max(div,1), k >= 1.
    int          m_mode = 0;
    int          m_t0 = 0;
    logic [15:0] m_div = 16'h0;
    logic [15:0] m_db = 16'h0;
    logic        m_pend_rx = 1'b0;
    logic        m_pend_tx = 1'b0;
    logic [7:0]  m_tx_data = 8'h00;
    logic        m_prev_cs = 1'b0;
    logic        m_prev_rw = 1'b0;
    logic [1:0]  m_prev_addr = 2'b00;

    logic        exp_en;
    logic        exp_rx_rd;
    logic        exp_tx_wr;
    logic [7:0]  exp_tx_data;
    logic        exp_bus_chk;
    logic [7:0]  exp_bus;

    // Drives one clock cycle of bus activity, leaves the expected outputs for that
    // cycle in exp_*, then folds the cycle's effects into the model.
    task automatic do_cycle(input logic r, input logic cs, input logic rw,
                            input logic [1:0] addr, input logic [7:0] wd);
        logic        first;
        logic [31:0] rv;
        int          p;
        @(posedge clk);
        cyc++;
        #1;
        rst    = r;
        iocs   = cs;
        iorw   = rw;
        ioaddr = addr;
        tb_wd  = wd;
        tb_drv = cs & ~rw;
        if (rnd_in) begin
            rv      = $urandom;
            rx_data = rv[7:0];
            rda     = rv[8];
            tbr     = rv[9];
        end
        @(negedge clk);
        p           = (m_div == 16'd0) ? 1 : int'(m_div);
        exp_en      = (m_mode == 2) && (cyc > m_t0) && (((cyc - m_t0) % p) == 0);
        exp_rx_rd   = m_pend_rx;
        exp_tx_wr   = m_pend_tx;
        exp_tx_data = m_tx_data;
        exp_bus_chk = cs;
        exp_bus     = wd;
        if (cs && rw) begin
            case (addr)
                2'd0:    exp_bus = rx_data;
                2'd1:    exp_bus = {6'b000000, tbr, rda};
                2'd2:    exp_bus = m_db[7:0];
                default: exp_bus = m_db[15:8];
            endcase
        end
        if (r) begin
            m_mode = 0; m_db = 16'h0; m_div = 16'h0;
            m_pend_rx = 1'b0; m_pend_tx = 1'b0; m_tx_data = 8'h00;
            m_prev_cs = 1'b0; m_prev_rw = 1'b0; m_prev_addr = 2'b00;
        end else begin
            first     = cs && (!m_prev_cs || (rw != m_prev_rw) || (addr != m_prev_addr));
            m_pend_rx = first && rw && (addr == 2'd0);
            m_pend_tx = first && !rw && (addr == 2'd0);
            if (m_pend_tx) m_tx_data = wd;
            if (first && !rw && addr == 2'd2) begin
                m_db[7:0] = wd;
                m_mode    = 1;
            end
            if (first && !rw && addr == 2'd3) begin
                m_db[15:8] = wd;
                if (m_mode != 0) begin
                    m_mode = 2;
                    m_t0   = cyc;
                    m_div  = m_db;
                end
            end
            m_prev_cs = cs; m_prev_rw = rw; m_prev_addr = addr;
        end
    endtask

    task automatic test_reset();
        int en_cnt;
        rnd_in = 1'b0; rda = 1'b0; tbr = 1'b0; rx_data = 8'h00;
        do_cycle(1, 0, 0, 2'd0, 8'h00);
        do_cycle(1, 0, 0, 2'd0, 8'h00);
        do_cycle(0, 0, 0, 2'd0, 8'h00);
        n_checks++;
        if (rx_rd !== 1'b0 || tx_wr !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_strobes rx_rd=%b tx_wr=%b required 0 0", rx_rd, tx_wr);
        end
        n_checks++;
        if (tx_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_tx_data got %h required 00", tx_data);
        end
        en_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            do_cycle(0, 0, 0, 2'd0, 8'h00);
            if (enable !== 1'b0) en_cnt++;
        end
        n_checks++;
        if (en_cnt != 0) begin
            n_errors++;
            $display("FAIL reset_no_ticks got %0d ticks required 0", en_cnt);
        end
        do_cycle(0, 1, 1, 2'd1, 8'h00);
        n_checks++;
        if (databus !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_status got %h required 00", databus);
        end
        do_cycle(0, 0, 0, 2'd0, 8'h00);
        rnd_in = 1'b1;
    endtask

    task automatic test_divisor();
        int t_hi, first_tick, ticks;
        do_cycle(0, 1, 0, 2'd2, 8'h05);
        do_cycle(0, 0, 0, 2'd0, 8'h00);
        do_cycle(0, 1, 0, 2'd3, 8'h00);
        t_hi = cyc; first_tick = -1; ticks = 0;
        for (int i = 0; i < 31; i++) begin
            do_cycle(0, 0, 0, 2'd0, 8'h00);
            n_checks++;
            if (enable !== exp_en) begin
                n_errors++;
                $display("FAIL div5_enable cyc=%0d got %b required %b", cyc, enable, exp_en);
            end
            if (enable === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = cyc;
            end
        end
        n_checks++;
        if (first_tick - t_hi != 5 || ticks != 6) begin
            n_errors++;
            $display("FAIL div5_timing first_delay=%0d ticks=%0d required 5 6", first_tick - t_hi, ticks);
        end
        do_cycle(0, 1, 1, 2'd2, 8'h00);
        n_checks++;
        if (databus !== 8'h05) begin
            n_errors++;
            $display("FAIL db_lo_readback got %h required 05", databus);
        end
        do_cycle(0, 0, 0, 2'd0, 8'h00);
    endtask

    task automatic test_retune();
        int t_hi, first_tick, ticks, stray;
        do_cycle(0, 1, 0, 2'd2, 8'h03);
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            do_cycle(0, 0, 0, 2'd0, 8'h00);
            if (enable !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_errors++;
            $display("FAIL retune_stopped got %0d ticks required 0", stray);
        end
        do_cycle(0, 1, 0, 2'd3, 8'h00);
        t_hi = cyc; first_tick = -1; ticks = 0;
        for (int i = 0; i < 13; i++) begin
            do_cycle(0, 0, 0, 2'd0, 8'h00);
            n_checks++;
            if (enable !== exp_en) begin
                n_errors++;
                $display("FAIL div3_enable cyc=%0d got %b required %b", cyc, enable, exp_en);
            end
            if (enable === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = cyc;
            end
        end
        n_checks++;
        if (first_tick - t_hi != 3 || ticks != 4) begin
            n_errors++;
            $display("FAIL div3_timing first_delay=%0d ticks=%0d required 3 4", first_tick - t_hi, ticks);
        end
    endtask

    task automatic test_read_hold();
        int pulses;
        rnd_in = 1'b0; rx_data = 8'hA5; rda = 1'b1; tbr = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            do_cycle(0, 1, 1, 2'd0, 8'h00);
            n_checks++;
            if (databus !== 8'hA5) begin
                n_errors++;
                $display("FAIL read_hold_bus beat=%0d got %h required a5", i, databus);
            end
            if (rx_rd === 1'b1) pulses++;
        end
        for (int i = 0; i < 2; i++) begin
            do_cycle(0, 0, 0, 2'd0, 8'h00);
            if (rx_rd === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1) begin
            n_errors++;
            $display("FAIL read_hold_rx_rd got %0d pulses required 1", pulses);
        end
        rnd_in = 1'b1;
    endtask

    task automatic test_write_hold();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            do_cycle(0, 1, 0, 2'd0, 8'h3C);
            n_checks++;
            if (databus !== 8'h3C) begin
                n_errors++;
                $display("FAIL write_bus_contention beat=%0d got %h required 3c", i, databus);
            end
            if (tx_wr === 1'b1) pulses++;
        end
        for (int i = 0; i < 2; i++) begin
            do_cycle(0, 0, 0, 2'd0, 8'h00);
            if (tx_wr === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 1 || tx_data !== 8'h3C) begin
            n_errors++;
            $display("FAIL write_hold pulses=%0d tx_data=%h required 1 3c", pulses, tx_data);
        end
    endtask

    task automatic test_back_to_back();
        int ticks, rd_p, wr_p;
        do_cycle(0, 1, 0, 2'd2, 8'h04);
        do_cycle(0, 1, 0, 2'd3, 8'h00);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 2'd0, 8'h00);
        do_cycle(0, 1, 0, 2'd3, 8'h00);
        n_checks++;
        if (enable !== 1'b1) begin
            n_errors++;
            $display("FAIL collision_tick got %b required 1", enable);
        end
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            do_cycle(0, 0, 0, 2'd0, 8'h00);
            n_checks++;
            if (enable !== exp_en) begin
                n_errors++;
                $display("FAIL collision_enable cyc=%0d got %b required %b", cyc, enable, exp_en);
            end
            if (enable === 1'b1) ticks++;
        end
        n_checks++;
        if (ticks != 2) begin
            n_errors++;
            $display("FAIL collision_rephase got %0d ticks required 2", ticks);
        end
        rd_p = 0; wr_p = 0;
        do_cycle(0, 1, 1, 2'd0, 8'h00);
        do_cycle(0, 1, 0, 2'd0, 8'h77);
        if (rx_rd === 1'b1) rd_p++;
        do_cycle(0, 0, 0, 2'd0, 8'h00);
        if (tx_wr === 1'b1) wr_p++;
        n_checks++;
        if (rd_p != 1 || wr_p != 1 || tx_data !== 8'h77) begin
            n_errors++;
            $display("FAIL b2b_strobes rx_rd=%0d tx_wr=%0d tx_data=%h required 1 1 77", rd_p, wr_p, tx_data);
        end
    endtask

    task automatic test_div0_reset();
        int bad;
        do_cycle(0, 1, 0, 2'd2, 8'h00);
        do_cycle(0, 1, 0, 2'd3, 8'h00);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            do_cycle(0, 0, 0, 2'd0, 8'h00);
            if (enable !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL div0_every_cycle got %0d missing ticks required 0", bad);
        end
        do_cycle(1, 0, 0, 2'd0, 8'h00);
        do_cycle(0, 0, 0, 2'd0, 8'h00);
        n_checks++;
        if (enable !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_run got %b required 0", enable);
        end
        do_cycle(0, 1, 0, 2'd3, 8'h05);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            do_cycle(0, 0, 0, 2'd0, 8'h00);
            if (enable !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL idle_hi_write got %0d ticks required 0", bad);
        end
    endtask

    task automatic test_random();
        logic [31:0] rv;
        logic        rw;
        logic [1:0]  addr;
        logic [7:0]  wd;
        int          len, gap;
        for (int t = 0; t < 300; t++) begin
            rv   = $urandom;
            rw   = rv[0];
            addr = rv[2:1];
            len  = 1 + int'(rv[4:3] % 2'd3);
            gap  = int'(rv[6:5] % 2'd3);
            wd   = (addr == 2'd3) ? ((rv[7] && rv[8]) ? 8'h01 : 8'h00)
                 : (addr == 2'd2) ? {4'h0, rv[12:9]} : rv[20:13];
            for (int b = 0; b < len + gap; b++) begin
                if (rv[31:25] == 7'd0 && b == 0)
                    do_cycle(1, 0, 0, 2'd0, 8'h00);
                else if (b < len)
                    do_cycle(0, 1, rw, addr, wd);
                else
                    do_cycle(0, 0, 0, 2'd0, 8'h00);
                n_checks++;
                if (enable !== exp_en) begin
                    n_errors++;
                    $display("FAIL rnd_enable cyc=%0d got %b required %b", cyc, enable, exp_en);
                end
                n_checks++;
                if (rx_rd !== exp_rx_rd || tx_wr !== exp_tx_wr) begin
                    n_errors++;
                    $display("FAIL rnd_strobes cyc=%0d got rx_rd=%b tx_wr=%b required %b %b",
                             cyc, rx_rd, tx_wr, exp_rx_rd, exp_tx_wr);
                end
                n_checks++;
                if (tx_data !== exp_tx_data) begin
                    n_errors++;
                    $display("FAIL rnd_tx_data cyc=%0d got %h required %h", cyc, tx_data, exp_tx_data);
                end
                if (exp_bus_chk) begin
                    n_checks++;
                    if (databus !== exp_bus) begin
                        n_errors++;
                        $display("FAIL rnd_bus cyc=%0d addr=%0d rw=%b got %h required %h",
                                 cyc, ioaddr, iorw, databus, exp_bus);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_divisor();
        test_retune();
        test_read_hold();
        test_write_hold();
        test_back_to_back();
        test_div0_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
